// File: rtl/pr_apply_wb_arbiter.sv
// PageRank apply write-back arbiter: four per-pipeline FIFOs feeding four
// vertex BRAM banks with per-bank round-robin grant, stall and drain handshake.
module pr_apply_wb_arbiter #(
  parameter int DST_ID_DWIDTH         = 32,
  parameter int VERTEX_BRAM_DWIDTH    = 32,
  parameter int VERTEX_BRAM_AWIDTH    = 10,
  parameter int VERTEX_BRAM_NUM_WIDTH = 2,
  parameter int WB_VALID_WIDTH        = 4,
  parameter int FIFO_DEPTH            = 8,
  parameter int AF_MARGIN             = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DST_ID_DWIDTH-1:0]      in_addr_0,
  input  logic [DST_ID_DWIDTH-1:0]      in_addr_1,
  input  logic [DST_ID_DWIDTH-1:0]      in_addr_2,
  input  logic [DST_ID_DWIDTH-1:0]      in_addr_3,
  input  logic [VERTEX_BRAM_DWIDTH-1:0] in_data_0,
  input  logic [VERTEX_BRAM_DWIDTH-1:0] in_data_1,
  input  logic [VERTEX_BRAM_DWIDTH-1:0] in_data_2,
  input  logic [VERTEX_BRAM_DWIDTH-1:0] in_data_3,
  input  logic [WB_VALID_WIDTH-1:0]     in_valid_0,
  input  logic [WB_VALID_WIDTH-1:0]     in_valid_1,
  input  logic [WB_VALID_WIDTH-1:0]     in_valid_2,
  input  logic [WB_VALID_WIDTH-1:0]     in_valid_3,
  output logic                          bram_we_0,
  output logic                          bram_we_1,
  output logic                          bram_we_2,
  output logic                          bram_we_3,
  output logic [VERTEX_BRAM_AWIDTH-1:0] bram_addr_0,
  output logic [VERTEX_BRAM_AWIDTH-1:0] bram_addr_1,
  output logic [VERTEX_BRAM_AWIDTH-1:0] bram_addr_2,
  output logic [VERTEX_BRAM_AWIDTH-1:0] bram_addr_3,
  output logic [VERTEX_BRAM_DWIDTH-1:0] bram_din_0,
  output logic [VERTEX_BRAM_DWIDTH-1:0] bram_din_1,
  output logic [VERTEX_BRAM_DWIDTH-1:0] bram_din_2,
  output logic [VERTEX_BRAM_DWIDTH-1:0] bram_din_3,
  output logic                          stall,
  output logic                          overflow_err,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [31:0]                   wb_count
);

  localparam int NR = 4;
  localparam int NB = WB_VALID_WIDTH;
  localparam int BW = $clog2(NB);
  localparam int RW = $clog2(NR);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = VERTEX_BRAM_AWIDTH;
  localparam int DW = VERTEX_BRAM_DWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  logic [DST_ID_DWIDTH-1:0] id_in  [NR];
  logic [DW-1:0]            dat_in [NR];
  logic [NB-1:0]            vld_in [NR];

  assign id_in[0]  = in_addr_0;
  assign id_in[1]  = in_addr_1;
  assign id_in[2]  = in_addr_2;
  assign id_in[3]  = in_addr_3;
  assign dat_in[0] = in_data_0;
  assign dat_in[1] = in_data_1;
  assign dat_in[2] = in_data_2;
  assign dat_in[3] = in_data_3;
  assign vld_in[0] = in_valid_0;
  assign vld_in[1] = in_valid_1;
  assign vld_in[2] = in_valid_2;
  assign vld_in[3] = in_valid_3;

  logic [BW-1:0] mbank_q [NR][FIFO_DEPTH];
  logic [AW-1:0] maddr_q [NR][FIFO_DEPTH];
  logic [DW-1:0] mdata_q [NR][FIFO_DEPTH];
  logic [CW-1:0] wr_q [NR];
  logic [CW-1:0] rd_q [NR];
  logic [CW-1:0] cnt  [NR];

  logic [BW-1:0] push_bank [NR];
  logic [BW-1:0] head_bank [NR];
  logic [AW-1:0] head_addr [NR];
  logic [DW-1:0] head_data [NR];
  logic [NR-1:0] push, acc, pop, nempty, full;
  logic          any_af;

  logic [RW-1:0] rr_q  [NB];
  logic [RW-1:0] rr_d  [NB];
  logic [RW-1:0] gnt_r [NB];
  logic [NB-1:0] gnt_v;

  logic [NB-1:0] bram_we_q;
  logic [AW-1:0] bram_addr_q [NB];
  logic [DW-1:0] bram_din_q  [NB];
  logic          stall_q, ovf_q;
  logic [31:0]   wbc_q;
  logic [2:0]    we_sum;
  state_t        state_q, state_d;

  always_comb begin
    any_af = 1'b0;
    for (int k = 0; k < NR; k++) begin
      cnt[k]       = wr_q[k] - rd_q[k];
      nempty[k]    = (cnt[k] != '0);
      full[k]      = (cnt[k] == CW'(FIFO_DEPTH));
      any_af       = any_af | (cnt[k] >= CW'(FIFO_DEPTH - AF_MARGIN));
      head_bank[k] = mbank_q[k][rd_q[k][PW-1:0]];
      head_addr[k] = maddr_q[k][rd_q[k][PW-1:0]];
      head_data[k] = mdata_q[k][rd_q[k][PW-1:0]];
      push[k]      = |vld_in[k];
      push_bank[k] = '0;
      // Scan high to low so a multi-hot select resolves to its lowest bit.
      for (int i = NB - 1; i >= 0; i--) begin
        if (vld_in[k][i]) push_bank[k] = BW'(i);
      end
    end
  end

  always_comb begin
    logic [RW-1:0] idx;
    idx   = '0;
    gnt_v = '0;
    pop   = '0;
    for (int b = 0; b < NB; b++) begin
      gnt_r[b] = '0;
      rr_d[b]  = rr_q[b];
      for (int i = 0; i < NR; i++) begin
        idx = rr_q[b] + RW'(i);
        if (!gnt_v[b] && nempty[idx] && head_bank[idx] == BW'(b)) begin
          gnt_v[b] = 1'b1;
          gnt_r[b] = idx;
          rr_d[b]  = idx + RW'(1);
        end
      end
      if (gnt_v[b]) pop[gnt_r[b]] = 1'b1;
    end
    acc = push & (~full | pop);
  end

  always_comb begin
    we_sum = '0;
    for (int b = 0; b < NB; b++) we_sum = we_sum + {2'b00, bram_we_q[b]};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (flush_req) state_d = S_DRAIN;
      S_DRAIN: if (!(|nempty) && !(|push) && !(|gnt_v)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Storage carries no reset: emptying is done by the pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NR; k++) begin
      if (acc[k]) begin
        mbank_q[k][wr_q[k][PW-1:0]] <= push_bank[k];
        maddr_q[k][wr_q[k][PW-1:0]] <=
          id_in[k][VERTEX_BRAM_NUM_WIDTH +: AW];
        mdata_q[k][wr_q[k][PW-1:0]] <= dat_in[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        wr_q[k] <= '0;
        rd_q[k] <= '0;
      end
      for (int b = 0; b < NB; b++) begin
        rr_q[b]        <= '0;
        bram_addr_q[b] <= '0;
        bram_din_q[b]  <= '0;
      end
      bram_we_q <= '0;
      stall_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wbc_q     <= '0;
      state_q   <= S_IDLE;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (acc[k]) wr_q[k] <= wr_q[k] + CW'(1);
        if (pop[k]) rd_q[k] <= rd_q[k] + CW'(1);
      end
      for (int b = 0; b < NB; b++) begin
        rr_q[b] <= rr_d[b];
        if (gnt_v[b]) begin
          bram_addr_q[b] <= head_addr[gnt_r[b]];
          bram_din_q[b]  <= head_data[gnt_r[b]];
        end
      end
      bram_we_q <= gnt_v;
      stall_q   <= any_af;
      if (|(push & ~acc)) ovf_q <= 1'b1;
      wbc_q   <= flush_req ? '0 : wbc_q + 32'(we_sum);
      state_q <= state_d;
    end
  end

  assign bram_we_0    = bram_we_q[0];
  assign bram_we_1    = bram_we_q[1];
  assign bram_we_2    = bram_we_q[2];
  assign bram_we_3    = bram_we_q[3];
  assign bram_addr_0  = bram_addr_q[0];
  assign bram_addr_1  = bram_addr_q[1];
  assign bram_addr_2  = bram_addr_q[2];
  assign bram_addr_3  = bram_addr_q[3];
  assign bram_din_0   = bram_din_q[0];
  assign bram_din_1   = bram_din_q[1];
  assign bram_din_2   = bram_din_q[2];
  assign bram_din_3   = bram_din_q[3];
  assign stall        = stall_q;
  assign overflow_err = ovf_q;
  assign flush_done   = (state_q == S_DONE);
  assign wb_count     = wbc_q;

endmodule

// File: tb/tb_pr_apply_wb_arbiter.sv
// Scoreboard bench for pr_apply_wb_arbiter: per-bank expected queues are
// filled as writes are issued and drained as bram_we is observed.
module tb_pr_apply_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_addr  [4];
  logic [31:0] in_data  [4];
  logic [3:0]  in_valid [4];
  logic [3:0]  we;
  logic [9:0]  baddr [4];
  logic [31:0] bdin  [4];
  logic        stall, overflow_err, flush_req, flush_done;
  logic [31:0] wb_count;

  always #5 clk = ~clk;

  pr_apply_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .in_addr_0(in_addr[0]), .in_addr_1(in_addr[1]),
    .in_addr_2(in_addr[2]), .in_addr_3(in_addr[3]),
    .in_data_0(in_data[0]), .in_data_1(in_data[1]),
    .in_data_2(in_data[2]), .in_data_3(in_data[3]),
    .in_valid_0(in_valid[0]), .in_valid_1(in_valid[1]),
    .in_valid_2(in_valid[2]), .in_valid_3(in_valid[3]),
    .bram_we_0(we[0]), .bram_we_1(we[1]),
    .bram_we_2(we[2]), .bram_we_3(we[3]),
    .bram_addr_0(baddr[0]), .bram_addr_1(baddr[1]),
    .bram_addr_2(baddr[2]), .bram_addr_3(baddr[3]),
    .bram_din_0(bdin[0]), .bram_din_1(bdin[1]),
    .bram_din_2(bdin[2]), .bram_din_3(bdin[3]),
    .stall(stall), .overflow_err(overflow_err),
    .flush_req(flush_req), .flush_done(flush_done),
    .wb_count(wb_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [41:0] sbq [4][$];
  logic [41:0] mon_e;
  int cyc = 0;
  int we_seen = 0;
  int first_we = -1;
  int last_we = 0;
  int done_seen = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          we_seen++;
          last_we = cyc;
          if (first_we < 0) first_we = cyc;
          if (sbq[b].size() == 0) begin
            chk($sformatf("unexp_we_b%0d", b), 64'(we[b]), 64'd0);
          end else begin
            mon_e = sbq[b].pop_front();
            chk($sformatf("addr_b%0d", b), 64'(baddr[b]), 64'(mon_e[41:32]));
            chk($sformatf("data_b%0d", b), 64'(bdin[b]), 64'(mon_e[31:0]));
          end
        end
      end
      if (flush_done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = '0;
      in_addr[k]  = '0;
      in_data[k]  = '0;
    end
    flush_req = 1'b0;
  endtask

  task automatic drive(input int k, input int b, input logic [31:0] id,
                       input logic [31:0] d, input bit exp);
    in_valid[k] = 4'(1 << b);
    in_addr[k]  = id;
    in_data[k]  = d;
    if (exp) sbq[b].push_back({id[11:2], d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    for (int b = 0; b < 4; b++) sbq[b].delete();
    step();
    rst = 1'b0;
  endtask

  function automatic int pending();
    return sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
  endfunction

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && pending() != 0; i++) step();
    for (int i = 0; i < 4; i++) step();
    chk(tag, 64'(pending()), 64'd0);
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", {baddr[0], baddr[1], baddr[2], baddr[3]}, 64'd0);
    chk("rst_din", 64'(bdin[0] | bdin[1] | bdin[2] | bdin[3]), 64'd0);
    chk("rst_flags", {stall, overflow_err, flush_done}, 64'd0);
    chk("rst_cnt", 64'(wb_count), 64'd0);

    // distinct banks, 2-cycle latency
    step();
    for (int k = 0; k < 4; k++)
      drive(k, k, 32'h10 * (k + 1), 32'h3F80_0000 + k, 1);
    step();
    idle_in();
    @(negedge clk);
    chk("dist_n1_we", 64'(we), 64'h0);
    step();
    @(negedge clk);
    chk("dist_n2_we", 64'(we), 64'hF);
    step();
    @(negedge clk);
    chk("dist_cnt", 64'(wb_count), 64'd4);
    chk("dist_n3_we", 64'(we), 64'h0);

    // full conflict on bank 2
    do_reset();
    drive(0, 2, 32'h100, 32'h3F80_0000, 1);
    drive(1, 2, 32'h104, 32'h4000_0000, 1);
    drive(2, 2, 32'h108, 32'h4040_0000, 1);
    drive(3, 2, 32'h10C, 32'h4080_0000, 1);
    step();
    idle_in();
    @(negedge clk);
    chk("conf_n1_we", 64'(we), 64'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk($sformatf("conf_n%0d_we", i + 2), 64'(we), 64'h4);
    end
    step();
    @(negedge clk);
    chk("conf_n6_we", 64'(we), 64'h0);
    step();
    // rr pointer back at 0: requester 0 beats requester 3
    drive(0, 2, 32'h200, 32'h1111_0000, 1);
    drive(3, 2, 32'h204, 32'h3333_0000, 1);
    step();
    idle_in();
    wait_drain("conf_drain");

    // round-robin fairness, requesters 1 and 3 on bank 0
    do_reset();
    first_we = -1;
    we_seen  = 0;
    for (int t = 0; t < 8; t++) begin
      drive(1, 0, 32'h400 + 32'(t * 4), 32'hA100_0000 + 32'(t), 1);
      drive(3, 0, 32'h800 + 32'(t * 4), 32'hA300_0000 + 32'(t), 1);
      step();
    end
    idle_in();
    wait_drain("fair_drain");
    chk("fair_count", 64'(we_seen), 64'd16);
    chk("fair_span", 64'(last_we - first_we + 1), 64'd16);

    // overflow: requester 1 outlasts requester 0 and overruns its FIFO
    do_reset();
    for (int t = 0; t < 16; t++) begin
      idle_in();
      if (t <= 14) drive(0, 0, 32'h1000 + 32'(t * 4), 32'hB000_0000 + 32'(t), 1);
      drive(1, 0, 32'h2000 + 32'(t * 4), 32'hC000_0000 + 32'(t), t != 15);
      @(negedge clk);
      if (t == 10) chk("ovf_stall_lo", 64'(stall), 64'd0);
      if (t == 11) chk("ovf_stall_hi", 64'(stall), 64'd1);
      if (t == 14) chk("ovf_err_lo", 64'(overflow_err), 64'd0);
      step();
    end
    idle_in();
    @(negedge clk);
    chk("ovf_err_hi", 64'(overflow_err), 64'd1);
    wait_drain("ovf_drain");
    chk("ovf_sticky", 64'(overflow_err), 64'd1);
    chk("ovf_stall_clr", 64'(stall), 64'd0);
    do_reset();
    @(negedge clk);
    chk("ovf_rst_clr", 64'(overflow_err), 64'd0);

    // flush: empty drain then a 5-entry drain
    step();
    for (int k = 0; k < 4; k++)
      drive(k, k, 32'h40 + 32'(k * 4), 32'hD000_0000 + k, 1);
    step();
    idle_in();
    wait_drain("fl_pre_drain");
    chk("fl_pre_cnt", 64'(wb_count), 64'd4);
    done_seen = 0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    @(negedge clk);
    chk("fl_empty_n1", 64'(flush_done), 64'd0);
    step();
    @(negedge clk);
    chk("fl_empty_n2", 64'(flush_done), 64'd1);
    step();
    @(negedge clk);
    chk("fl_empty_n3", 64'(flush_done), 64'd0);
    chk("fl_empty_cnt", 64'(wb_count), 64'd0);
    step();
    done_seen = 0;
    for (int k = 0; k < 4; k++)
      drive(k, 3, 32'h600 + 32'(k * 4), 32'hE000_0000 + k, 1);
    step();
    idle_in();
    drive(0, 3, 32'h700, 32'hE000_0010, 1);
    flush_req = 1'b1;
    step();
    idle_in();
    wait_drain("fl_drain");
    for (int i = 0; i < 20 && done_seen == 0; i++) step();
    chk("fl_done_once", 64'(done_seen), 64'd1);
    chk("fl_done_cyc", 64'(done_cyc), 64'(last_we + 1));
    chk("fl_cnt", 64'(wb_count), 64'd5);

    // reset with FIFOs half full
    do_reset();
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++)
        drive(k, 0, 32'h3000 + 32'(t * 16 + k * 4), 32'hF000_0000 + 32'(t * 4 + k), 1);
      step();
    end
    do_reset();
    @(negedge clk);
    chk("mrst_we", 64'(we), 64'd0);
    chk("mrst_flags", {stall, overflow_err, flush_done}, 64'd0);
    chk("mrst_cnt", 64'(wb_count), 64'd0);
    chk("mrst_addr", {baddr[0], baddr[1], baddr[2], baddr[3]}, 64'd0);
    we_seen = 0;
    for (int i = 0; i < 10; i++) step();
    chk("mrst_no_we", 64'(we_seen), 64'd0);
    // multi-hot select resolves to bank 1
    in_valid[2] = 4'b1010;
    in_addr[2]  = 32'h5A4;
    in_data[2]  = 32'h1234_5678;
    sbq[1].push_back({10'h169, 32'h1234_5678});
    step();
    idle_in();
    @(negedge clk);
    chk("mrst_n1_we", 64'(we), 64'h0);
    step();
    @(negedge clk);
    chk("mrst_n2_we", 64'(we), 64'h2);
    wait_drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
